// File: rtl/gpio_pattern_gen.sv
// gpio_pattern_gen: programmable GPIO pattern generator.
//
// A prescaler produces a one-cycle tick every div+1 enabled cycles; each tick
// advances the pattern one step in the selected mode (rotate left, rotate
// right, bounce, binary count). A valid/ready port seeds the pattern at run
// time and restarts the prescaler and the bounce sweep.
//
// Build option: define GPIO_PATTERN_BOUNCE_EN to enable the bounce mode.
// Without it, mode 2 behaves as rotate left, dir is tied low and no bounce
// position register exists.
//
// Bounce direction (dir):
//   dir | meaning
//   0   | sweeping left, bpos counting up toward WIDTH-1
//   1   | sweeping right, bpos counting down toward 0

module gpio_pattern_gen #(
    parameter int WIDTH = 32,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic [WIDTH-1:0] pattern,
    output logic             tick,
    output logic             dir
);

    localparam logic [WIDTH-1:0] PATTERN_RST = {{(WIDTH-1){1'b1}}, 1'b0};

    logic             accept;
    logic [DIV_W-1:0] cnt;

    assign accept = load_valid && load_ready;

    // Ready comes up one edge after reset release and never drops again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_ready <= 1'b0;
        end else begin
            load_ready <= 1'b1;
        end
    end

    // Prescaler: a load restarts the period; a div lowered below cnt lets cnt
    // wrap through 2^DIV_W before it matches again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (accept) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            if (cnt == div) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + DIV_W'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

`ifdef GPIO_PATTERN_BOUNCE_EN
    localparam int BPOS_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [BPOS_W-1:0] BPOS_LAST = BPOS_W'(WIDTH - 1);

    logic [BPOS_W-1:0] bpos;
    logic              dir_q;
    logic [BPOS_W-1:0] bpos_up;
    logic [BPOS_W-1:0] bpos_dn;

    assign dir     = dir_q;
    assign bpos_up = bpos + BPOS_W'(1);
    assign bpos_dn = bpos - BPOS_W'(1);

    // Pattern step plus bounce tracking; a load wins over a coincident tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern <= PATTERN_RST;
            bpos    <= '0;
            dir_q   <= 1'b0;
        end else if (accept) begin
            pattern <= load_data;
            bpos    <= '0;
            dir_q   <= 1'b0;
        end else if (tick) begin
            case (mode)
                2'd0: pattern <= {pattern[WIDTH-2:0], pattern[WIDTH-1]};
                2'd1: pattern <= {pattern[0], pattern[WIDTH-1:1]};
                2'd2: begin
                    if (!dir_q) begin
                        pattern <= {pattern[WIDTH-2:0], pattern[WIDTH-1]};
                        bpos    <= bpos_up;
                        if (bpos_up == BPOS_LAST) dir_q <= 1'b1;
                    end else begin
                        pattern <= {pattern[0], pattern[WIDTH-1:1]};
                        bpos    <= bpos_dn;
                        if (bpos_dn == '0) dir_q <= 1'b0;
                    end
                end
                default: pattern <= pattern + WIDTH'(1);
            endcase
        end
    end
`else
    assign dir = 1'b0;

    // Pattern step; a load wins over a coincident tick. Mode 2 rotates left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern <= PATTERN_RST;
        end else if (accept) begin
            pattern <= load_data;
        end else if (tick) begin
            case (mode)
                2'd0, 2'd2: pattern <= {pattern[WIDTH-2:0], pattern[WIDTH-1]};
                2'd1:       pattern <= {pattern[0], pattern[WIDTH-1:1]};
                default:    pattern <= pattern + WIDTH'(1);
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_gpio_pattern_gen.sv
// Directed bench for gpio_pattern_gen at WIDTH=8, DIV_W=4.
// Bounce expectations follow GPIO_PATTERN_BOUNCE_EN as the DUT does.

module tb_gpio_pattern_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] div;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic [7:0] pattern;
    logic       tick;
    logic       dir;

    int n_cmp = 0;
    int n_mis = 0;

    gpio_pattern_gen #(.WIDTH(8), .DIV_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .div        (div),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .pattern    (pattern),
        .tick       (tick),
        .dir        (dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] rl_tab [9] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
    logic [7:0] e;

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'd0; div = 4'd3;
        load_valid = 1'b0; load_data = 8'h00;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_pattern", 32'(pattern), 32'hFE);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_dir", 32'(dir), 32'h0);
        check("rst_ready", 32'(load_ready), 32'h0);

        rst = 1'b0;
        step();
        check("ready_after_release", 32'(load_ready), 32'h1);

        // Rotate left with div=3: tick every 4 cycles, full cycle after 8 steps
        en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            repeat (3) begin
                step();
                check("rl_tick_gap", 32'(tick), 32'h0);
            end
            step();
            check("rl_tick", 32'(tick), 32'h1);
            check("rl_pattern", 32'(pattern), 32'(rl_tab[k]));
        end

        // Drop en: the already-registered tick still steps, then everything freezes
        en = 1'b0;
        step();
        check("en_low_last_step", 32'(pattern), 32'hFD);
        repeat (5) begin
            step();
            check("en_low_tick", 32'(tick), 32'h0);
            check("en_low_hold", 32'(pattern), 32'hFD);
        end
        en = 1'b1;
        repeat (3) step();
        step();
        check("en_resume_tick", 32'(tick), 32'h1);

        // Async reset, then rotate right with div=0
        rst = 1'b1;
        #1;
        check("async_rst_pattern", 32'(pattern), 32'hFE);
        check("async_rst_tick", 32'(tick), 32'h0);
        mode = 2'd1; div = 4'd0; en = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("rr_tick", 32'(tick), 32'h1);
        check("rr_p0", 32'(pattern), 32'hFE);
        step();
        check("rr_p1", 32'(pattern), 32'h7F);
        step();
        check("rr_p2", 32'(pattern), 32'hBF);

        // Bounce from 0x01 at div=0
        mode = 2'd2; load_valid = 1'b1; load_data = 8'h01;
        step();
        load_valid = 1'b0;
        check("bn_load", 32'(pattern), 32'h01);
        check("bn_load_tick", 32'(tick), 32'h0);
        step();
        check("bn_first_tick", 32'(tick), 32'h1);
        check("bn_hold", 32'(pattern), 32'h01);
        for (int i = 1; i <= 7; i++) begin
            step();
            e = 8'h01 << i;
            check("bn_up", 32'(pattern), 32'(e));
`ifdef GPIO_PATTERN_BOUNCE_EN
            check("bn_up_dir", 32'(dir), (i == 7) ? 32'h1 : 32'h0);
`else
            check("bn_up_dir", 32'(dir), 32'h0);
`endif
        end
`ifdef GPIO_PATTERN_BOUNCE_EN
        for (int i = 1; i <= 7; i++) begin
            step();
            e = 8'h80 >> i;
            check("bn_down", 32'(pattern), 32'(e));
            check("bn_down_dir", 32'(dir), (i == 7) ? 32'h0 : 32'h1);
        end
`else
        step();
        check("bn_wrap", 32'(pattern), 32'h01);
        check("bn_wrap_dir", 32'(dir), 32'h0);
`endif

        // Count up through the all-ones wrap
        mode = 2'd3; load_valid = 1'b1; load_data = 8'hFE;
        step();
        load_valid = 1'b0;
        check("cnt_load", 32'(pattern), 32'hFE);
        step();
        check("cnt_tick", 32'(tick), 32'h1);
        check("cnt_hold", 32'(pattern), 32'hFE);
        step();
        check("cnt_ff", 32'(pattern), 32'hFF);
        step();
        check("cnt_wrap", 32'(pattern), 32'h00);
        step();
        check("cnt_01", 32'(pattern), 32'h01);

        // Load coincident with tick: load wins, period restarts
        mode = 2'd0; div = 4'd3; load_valid = 1'b1; load_data = 8'h80;
        step();
        load_valid = 1'b0;
        check("lt_seed", 32'(pattern), 32'h80);
        check("lt_seed_tick", 32'(tick), 32'h0);
        repeat (3) step();
        step();
        check("lt_tick", 32'(tick), 32'h1);
        check("lt_pre", 32'(pattern), 32'h80);
        load_valid = 1'b1; load_data = 8'h55;
        step();
        load_valid = 1'b0;
        check("lt_load_wins", 32'(pattern), 32'h55);
        check("lt_tick_cleared", 32'(tick), 32'h0);
        repeat (3) begin
            step();
            check("lt_gap_tick", 32'(tick), 32'h0);
            check("lt_gap_hold", 32'(pattern), 32'h55);
        end
        step();
        check("lt_next_tick", 32'(tick), 32'h1);
        step();
        check("lt_step", 32'(pattern), 32'hAA);
        step();

        // Reset mid-count
        rst = 1'b1;
        #1;
        check("mid_rst_pattern", 32'(pattern), 32'hFE);
        check("mid_rst_tick", 32'(tick), 32'h0);
        check("mid_rst_dir", 32'(dir), 32'h0);
        check("mid_rst_ready", 32'(load_ready), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/gpio_pattern_gen.md
# gpio_pattern_gen

Parametrised GPIO pattern generator driving board GPIO banks from the 125 MHz PCIe system clock domain. It is the successor to the fixed 32-bit walking-zero wiggle. It adds:
- programmable width and step prescaler
- four step modes (rotate left, rotate right, bounce, binary count)
- a valid/ready load port for seeding the pattern at run time

## Interface
Parameters:
- WIDTH, 32, pattern / GPIO bank width (>= 2)
- DIV_W, 24, prescaler divisor width

Ports:
- clk  in  1  clock; reset rst, asynchronous, active-high; clock clk
- rst  in  1  asynchronous active-high reset
- en  in  1  step enable; low freezes prescaler and pattern
- mode  in  2  0 rotate left, 1 rotate right, 2 bounce, 3 count up
- div  in  DIV_W  step period minus one, in clk cycles
- load_valid  in  1  load request
- load_data  in  WIDTH  pattern to load
- load_ready  out  1  load accept; registered
- pattern  out  WIDTH  current pattern, registered, drives GPIO
- tick  out  1  one-cycle step strobe, registered
- dir  out  1  bounce direction, 0 left / 1 right

## Operation
- Reset values:
  - pattern = all ones except bit 0 = 0 (WIDTH=8: 0xFE)
  - tick = 0, dir = 0, load_ready = 0
  - prescaler cnt = 0, bounce position bpos = 0
- load_ready rises on the first clk edge after rst deasserts and then stays 1.
- Prescaler, when en = 1:
  - if cnt == div: cnt <= 0 and tick <= 1
  - otherwise: cnt <= cnt+1 and tick <= 0
- With en = 0: cnt holds and tick <= 0.
- Step: on any edge where tick == 1 and no load is accepted, pattern updates according to mode, sampled at that edge:
  - 0: rotate left; bit WIDTH-1 moves to bit 0
  - 1: rotate right; bit 0 moves to bit WIDTH-1
  - 2: bounce
    - dir = 0: rotate left, bpos+1; when bpos reaches WIDTH-1, set dir <= 1
    - dir = 1: rotate right, bpos-1; when bpos reaches 0, set dir <= 0
    - period is 2*(WIDTH-1) ticks
  - 3: pattern + 1 modulo 2^WIDTH; all ones wraps to 0
- bpos and dir change only in mode 2. Switching mode leaves them held.
- Load: accepted when load_valid && load_ready, whatever the state of en. On accept:
  - pattern <= load_data
  - cnt <= 0, tick <= 0
  - bpos <= 0, dir <= 0
- Simultaneous load and tick: the load wins and the step is discarded.
- rst mid-operation returns every register to its reset value immediately. An in-flight load is dropped.
- Changing div mid-period: it takes effect on the next compare. If cnt > new div, cnt counts up, wraps at 2^DIV_W, and then matches.

## Timing
- tick is high for one cycle every div+1 cycles while en = 1. With div = 0, tick stays high continuously and pattern steps every cycle.
- pattern changes on the edge after the cycle in which tick is high (1-cycle latency).
- Load to pattern: 1 cycle. The first tick after a load occurs div+1 cycles after the accept edge.
- load_ready is never deasserted after reset release. Loads are single-cycle handshakes.

## Configuration
- GPIO_PATTERN_BOUNCE_EN
  - Defined: mode 2 behaves as bounce, and bpos and dir logic is present.
  - Undefined: mode 2 behaves exactly as mode 0, dir is tied 0, and no bpos register exists.

## Test plan
Bench uses WIDTH=8, DIV_W=4.
- Reset and release: pattern=0xFE, tick=0, dir=0 during rst; load_ready=1 one cycle after release.
- div=3, mode=0, en=1: tick every 4 cycles; pattern 0xFE->0xFD->0xFB; back to 0xFE after 8 ticks. Drop en for 5 cycles -> no tick, pattern holds.
- mode=1 from reset: 0xFE->0x7F->0xBF.
- Bounce (macro defined): load 0x01, div=0 -> 0x02..0x80 over 7 ticks with dir=1 on reaching 0x80, then 0x40..0x01, returning to 0x01 after 14 ticks. Macro undefined: 0x80->0x01.
- mode=3, load 0xFE -> 0xFF, then 0x00 (wrap), then 0x01.
- div=3, load 0x55 asserted in the same cycle tick=1 -> pattern=0x55 with no step; next tick 4 cycles later. Assert rst mid-count -> pattern=0xFE at once.
